// File: rtl/data_ram_hs_pkg.sv
// data_ram_hs_pkg: shared state encoding and per-lane helpers for data_ram_hs.
`default_nettype none

package data_ram_hs_pkg;

    typedef enum logic [0:0] {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Lane merge: the byte is replaced only when its write enable is set.
    function automatic logic [7:0] byte_merge(input logic [7:0] old_b,
                                              input logic [7:0] new_b,
                                              input logic       wen);
        return wen ? new_b : old_b;
    endfunction

    // Even parity bit: makes the 9-bit group carry an even number of ones.
    function automatic logic parity8(input logic [7:0] b);
        return ^b;
    endfunction

endpackage

`default_nettype wire

// File: rtl/data_ram_hs_clr.sv
// data_ram_hs_clr: clear sequencer that walks every word after reset or on clr_req.
`default_nettype none

module data_ram_hs_clr
    import data_ram_hs_pkg::*;
#(
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_req,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr,
    output logic              busy
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] clr_cnt;
    logic [ADDR_W-1:0] clr_cnt_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= INIT;
            clr_cnt <= '0;
            busy    <= 1'b1;
        end else begin
            state   <= state_nxt;
            clr_cnt <= clr_cnt_nxt;
            busy    <= (state_nxt == INIT);
        end
    end

    always_comb begin
        state_nxt   = state;
        clr_cnt_nxt = clr_cnt;
        clr_we      = 1'b0;
        case (state)
            INIT: begin
                clr_we = 1'b1;
                // Terminal compare rather than relying on counter wrap.
                if (clr_cnt == LAST_ADDR) begin
                    state_nxt   = RUN;
                    clr_cnt_nxt = '0;
                end else begin
                    clr_cnt_nxt = clr_cnt + ADDR_W'(1);
                end
            end
            RUN: begin
                if (clr_req) begin
                    state_nxt = INIT;
                end
            end
        endcase
    end

    assign clr_addr = clr_cnt;

endmodule

`default_nettype wire

// File: rtl/data_ram_hs.sv
// data_ram_hs: byte-enabled handshaked data RAM with clear sequencer and debug port.
// Optional per-byte even parity with error flag and injection: DATA_RAM_HS_PARITY_EN.
`default_nettype none

module data_ram_hs
    import data_ram_hs_pkg::*;
#(
    parameter int                DATA_W   = 32,
    parameter int                ADDR_W   = 5,
    parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr_req,
    output logic                busy,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [DATA_W/8-1:0] req_wen,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_rdata,
`ifdef DATA_RAM_HS_PARITY_EN
    input  logic                inj_par,
    output logic                par_err,
`endif
    input  logic [ADDR_W-1:0]   test_addr,
    output logic [DATA_W-1:0]   test_data
);

    localparam int NB    = DATA_W / 8;
    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;
    logic              req_fire;
    logic              wr_fire;
    logic              rd_fire;
    logic [DATA_W-1:0] wr_word;

    data_ram_hs_clr #(
        .ADDR_W (ADDR_W)
    ) u_clr (
        .clk      (clk),
        .rst      (rst),
        .clr_req  (clr_req),
        .clr_we   (clr_we),
        .clr_addr (clr_addr),
        .busy     (busy)
    );

    // Stall whenever the response slot is occupied and not draining this cycle.
    assign req_ready = ~busy & ~clr_req & (~rsp_valid | rsp_ready);
    assign req_fire  = req_valid & req_ready;
    assign wr_fire   = req_fire & (|req_wen);
    assign rd_fire   = req_fire & ~(|req_wen);

    always_comb begin
        wr_word = mem[req_addr];
        for (int i = 0; i < NB; i++) begin
            wr_word[8*i +: 8] = byte_merge(mem[req_addr][8*i +: 8], req_wdata[8*i +: 8], req_wen[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_addr] <= INIT_VAL;
        end else if (wr_fire) begin
            mem[req_addr] <= wr_word;
        end
    end

    assign test_data = mem[test_addr];

`ifdef DATA_RAM_HS_PARITY_EN
    logic [NB-1:0] par_mem [DEPTH];
    logic [NB-1:0] init_par;
    logic [NB-1:0] wr_par;
    logic [NB-1:0] rd_bad;

    always_comb begin
        init_par = '0;
        wr_par   = '0;
        rd_bad   = '0;
        for (int i = 0; i < NB; i++) begin
            init_par[i] = parity8(INIT_VAL[8*i +: 8]);
            wr_par[i]   = req_wen[i] ? (parity8(req_wdata[8*i +: 8]) ^ inj_par) : par_mem[req_addr][i];
            rd_bad[i]   = parity8(mem[req_addr][8*i +: 8]) ^ par_mem[req_addr][i];
        end
    end

    always_ff @(posedge clk) begin
        if (clr_we) begin
            par_mem[clr_addr] <= init_par;
        end else if (wr_fire) begin
            par_mem[req_addr] <= wr_par;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
`ifdef DATA_RAM_HS_PARITY_EN
            par_err   <= 1'b0;
`endif
        end else if (clr_req && !busy) begin
            // Re-clear discards any pending read data.
            rsp_valid <= 1'b0;
        end else if (rd_fire) begin
            rsp_valid <= 1'b1;
            rsp_rdata <= mem[req_addr];
`ifdef DATA_RAM_HS_PARITY_EN
            par_err   <= |rd_bad;
`endif
        end else if (rsp_valid && rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_data_ram_hs.sv
// tb_data_ram_hs: randomized self-checking bench for data_ram_hs against an array model.
`default_nettype none

module tb_data_ram_hs;

    logic        clk = 1'b0;
    logic        rst;
    logic        clr_req;
    logic        busy;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_wen;
    logic [4:0]  req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic [4:0]  test_addr;
    logic [31:0] test_data;
`ifdef DATA_RAM_HS_PARITY_EN
    logic        inj_par;
    logic        par_err;
    logic [3:0]  bad_m [32];
`endif

    logic [31:0] model [32];
    int checks = 0;
    int fails  = 0;

    data_ram_hs #(
        .DATA_W   (32),
        .ADDR_W   (5),
        .INIT_VAL (32'h0)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .clr_req   (clr_req),
        .busy      (busy),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_wen   (req_wen),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
`ifdef DATA_RAM_HS_PARITY_EN
        .inj_par   (inj_par),
        .par_err   (par_err),
`endif
        .test_addr (test_addr),
        .test_data (test_data)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic model_clear();
        for (int i = 0; i < 32; i++) begin
            model[i] = 32'h0;
`ifdef DATA_RAM_HS_PARITY_EN
            bad_m[i] = 4'h0;
`endif
        end
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (req_ready !== 1'b1 && n < 64) begin
            @(posedge clk); #2;
            n++;
        end
        checks++;
        if (n >= 64) begin
            fails++;
            $display("FAIL %s: req_ready timeout, got %b want 1", tag, req_ready);
        end
    endtask

    // Returns at the sample point just after the accepting edge.
    task automatic do_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] w);
        req_valid = 1'b1; req_addr = a; req_wdata = d; req_wen = w;
        #1;
        wait_ready("write");
        @(posedge clk); #1;
        req_valid = 1'b0; req_wen = 4'h0;
        for (int i = 0; i < 4; i++) begin
            if (w[i]) begin
                model[a][8*i +: 8] = d[8*i +: 8];
`ifdef DATA_RAM_HS_PARITY_EN
                bad_m[a][i] = inj_par;
`endif
            end
        end
        #1;
    endtask

    task automatic do_read(input logic [4:0] a);
        req_valid = 1'b1; req_addr = a; req_wen = 4'h0;
        #1;
        wait_ready("read");
        @(posedge clk); #1;
        req_valid = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        int n;
        repeat (3) @(posedge clk);
        #2;
        checks++; if (busy !== 1'b1) begin fails++; $display("FAIL reset_busy: got %b want 1", busy); end
        checks++; if (req_ready !== 1'b0) begin fails++; $display("FAIL reset_req_ready: got %b want 0", req_ready); end
        checks++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
        checks++; if (rsp_rdata !== 32'h0) begin fails++; $display("FAIL reset_rsp_rdata: got %h want 0", rsp_rdata); end
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            @(posedge clk); #2;
        end
        checks++; if (n != 32) begin fails++; $display("FAIL init_busy_cycles: got %0d want 32", n); end
        checks++; if (req_ready !== 1'b1) begin fails++; $display("FAIL init_ready: got %b want 1", req_ready); end
        model_clear();
        for (int i = 0; i < 32; i++) begin
            test_addr = 5'(i);
            #1;
            checks++;
            if (test_data !== model[i]) begin
                fails++; $display("FAIL init_test_data[%0d]: got %h want %h", i, test_data, model[i]);
            end
        end
    endtask

    task automatic test_byte_write();
        do_write(5'd3, 32'hAABBCCDD, 4'b1111);
        do_write(5'd3, 32'h11223344, 4'b0101);
        do_read(5'd3);
        checks++; if (rsp_valid !== 1'b1) begin fails++; $display("FAIL byte_write_valid: got %b want 1", rsp_valid); end
        checks++; if (rsp_rdata !== model[3]) begin fails++; $display("FAIL byte_write_data: got %h want %h", rsp_rdata, model[3]); end
        @(posedge clk); #2;
    endtask

    task automatic test_backpressure();
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_addr = 5'd3; req_wen = 4'h0;
        #1;
        wait_ready("bp_first");
        @(posedge clk); #1;
        req_addr = 5'd4;
        #1;
        for (int k = 0; k < 4; k++) begin
            checks++; if (rsp_valid !== 1'b1) begin fails++; $display("FAIL bp_hold_valid[%0d]: got %b want 1", k, rsp_valid); end
            checks++; if (rsp_rdata !== model[3]) begin fails++; $display("FAIL bp_hold_data[%0d]: got %h want %h", k, rsp_rdata, model[3]); end
            checks++; if (req_ready !== 1'b0) begin fails++; $display("FAIL bp_ready_low[%0d]: got %b want 0", k, req_ready); end
            @(posedge clk); #2;
        end
        rsp_ready = 1'b1;
        #1;
        checks++; if (req_ready !== 1'b1) begin fails++; $display("FAIL bp_release_ready: got %b want 1", req_ready); end
        @(posedge clk); #1;
        req_valid = 1'b0;
        #1;
        checks++; if (rsp_valid !== 1'b1) begin fails++; $display("FAIL bp_queued_valid: got %b want 1", rsp_valid); end
        checks++; if (rsp_rdata !== model[4]) begin fails++; $display("FAIL bp_queued_data: got %h want %h", rsp_rdata, model[4]); end
        @(posedge clk); #2;
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 8; k++) begin
            do_write(5'(k), $urandom, 4'hF);
        end
        rsp_ready = 1'b1;
        req_valid = 1'b1; req_addr = 5'd0; req_wen = 4'h0;
        #1;
        for (int k = 0; k < 8; k++) begin
            checks++; if (req_ready !== 1'b1) begin fails++; $display("FAIL b2b_ready[%0d]: got %b want 1", k, req_ready); end
            @(posedge clk); #1;
            if (k < 7) req_addr = 5'(k + 1);
            else       req_valid = 1'b0;
            #1;
            checks++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== model[k]) begin
                fails++; $display("FAIL b2b_rsp[%0d]: got valid=%b data=%h want valid=1 data=%h", k, rsp_valid, rsp_rdata, model[k]);
            end
        end
        @(posedge clk); #2;
        checks++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL b2b_drain: got %b want 0", rsp_valid); end
    endtask

    task automatic test_random();
        logic [4:0]  a;
        logic [3:0]  w;
        logic [31:0] d;
        rsp_ready = 1'b1;
        for (int it = 0; it < 60; it++) begin
            a = 5'($urandom_range(0, 31));
            w = 4'($urandom_range(0, 15));
            d = $urandom;
            if (w == 4'h0) begin
                do_read(a);
                checks++;
                if (rsp_valid !== 1'b1 || rsp_rdata !== model[a]) begin
                    fails++; $display("FAIL rand_read[%0d] addr %0d: got valid=%b data=%h want valid=1 data=%h", it, a, rsp_valid, rsp_rdata, model[a]);
                end
            end else begin
                do_write(a, d, w);
            end
            test_addr = 5'($urandom_range(0, 31));
            #1;
            checks++;
            if (test_data !== model[test_addr]) begin
                fails++; $display("FAIL rand_test_data addr %0d: got %h want %h", test_addr, test_data, model[test_addr]);
            end
        end
        @(posedge clk); #2;
    endtask

    task automatic test_clear();
        int n;
        do_write(5'd3, 32'h5A5A_0F0F, 4'hF);
        rsp_ready = 1'b0;
        do_read(5'd3);
        checks++; if (rsp_valid !== 1'b1) begin fails++; $display("FAIL clr_pending_valid: got %b want 1", rsp_valid); end
        clr_req = 1'b1;
        #1;
        checks++; if (req_ready !== 1'b0) begin fails++; $display("FAIL clr_req_ready: got %b want 0", req_ready); end
        @(posedge clk); #1;
        clr_req = 1'b0;
        #1;
        checks++; if (rsp_valid !== 1'b0) begin fails++; $display("FAIL clr_drop_valid: got %b want 0", rsp_valid); end
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            @(posedge clk); #2;
        end
        checks++; if (n != 32) begin fails++; $display("FAIL clr_busy_cycles: got %0d want 32", n); end
        model_clear();
        rsp_ready = 1'b1;
        do_read(5'd3);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== model[3]) begin
            fails++; $display("FAIL clr_read3: got valid=%b data=%h want valid=1 data=%h", rsp_valid, rsp_rdata, model[3]);
        end
        @(posedge clk); #2;
    endtask

    task automatic test_reset_mid();
        int n;
        do_write(5'd20, 32'hDEADBEEF, 4'hF);
        do_write(5'd5, 32'h12345678, 4'hF);
        clr_req = 1'b1;
        @(posedge clk); #1;
        clr_req = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        // Words 0..9 are cleared, word 20 is not reached yet.
        test_addr = 5'd20;
        #1;
        checks++; if (test_data !== model[20]) begin fails++; $display("FAIL mid_partial_hi: got %h want %h", test_data, model[20]); end
        test_addr = 5'd5;
        #1;
        checks++; if (test_data !== 32'h0) begin fails++; $display("FAIL mid_partial_lo: got %h want 0", test_data); end
        rst = 1'b1;
        #1;
        checks++; if (busy !== 1'b1 || req_ready !== 1'b0) begin fails++; $display("FAIL mid_rst_state: got busy=%b ready=%b want busy=1 ready=0", busy, req_ready); end
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            @(posedge clk); #2;
        end
        checks++; if (n != 32) begin fails++; $display("FAIL mid_busy_cycles: got %0d want 32", n); end
        model_clear();
        test_addr = 5'd20;
        #1;
        checks++; if (test_data !== model[20]) begin fails++; $display("FAIL mid_cleared_20: got %h want %h", test_data, model[20]); end
        do_read(5'd20);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== model[20]) begin
            fails++; $display("FAIL mid_read20: got valid=%b data=%h want valid=1 data=%h", rsp_valid, rsp_rdata, model[20]);
        end
        @(posedge clk); #2;
    endtask

`ifdef DATA_RAM_HS_PARITY_EN
    task automatic test_parity();
        logic [31:0] d;
        d = $urandom;
        inj_par = 1'b1;
        do_write(5'd9, d, 4'hF);
        inj_par = 1'b0;
        do_read(5'd9);
        checks++;
        if (par_err !== (|bad_m[9]) || rsp_rdata !== model[9]) begin
            fails++; $display("FAIL par_inject: got par_err=%b data=%h want par_err=%b data=%h", par_err, rsp_rdata, |bad_m[9], model[9]);
        end
        do_write(5'd9, ~d, 4'hF);
        do_read(5'd9);
        checks++;
        if (par_err !== (|bad_m[9]) || rsp_rdata !== model[9]) begin
            fails++; $display("FAIL par_rewrite: got par_err=%b data=%h want par_err=%b data=%h", par_err, rsp_rdata, |bad_m[9], model[9]);
        end
        @(posedge clk); #2;
    endtask
`endif

    initial begin
        rst       = 1'b1;
        clr_req   = 1'b0;
        req_valid = 1'b0;
        req_wen   = 4'h0;
        req_addr  = 5'd0;
        req_wdata = 32'h0;
        rsp_ready = 1'b1;
        test_addr = 5'd0;
`ifdef DATA_RAM_HS_PARITY_EN
        inj_par   = 1'b0;
`endif
        model_clear();

        test_reset();
        test_byte_write();
        test_backpressure();
        test_back_to_back();
        test_random();
        test_clear();
        test_reset_mid();
`ifdef DATA_RAM_HS_PARITY_EN
        test_parity();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

`default_nettype wire
